// File: rtl/tcam_pkg.sv
// Shared types and width helpers for the TCAM search sequencer.
package tcam_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned frag_wid(input int unsigned data_bits,
                                           input int unsigned fragments);
    return data_bits / fragments;
  endfunction

  function automatic int unsigned addr_wid(input int unsigned frag_bits,
                                           input int unsigned fw);
    return frag_bits + fw;
  endfunction

endpackage

// File: rtl/tcam_match_accumulator.sv
// AND-accumulates per-fragment rule match vectors and counts returned responses.
module tcam_match_accumulator
  import tcam_pkg::*;
#(
  parameter int unsigned RULES = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             beat,
  input  logic [RULES-1:0] data,
  output logic [RULES-1:0] acc_nxt,
  output logic             acc_zero_nxt,
  output logic [CNT_W-1:0] rsp_cnt
);

  logic [RULES-1:0] acc;

  // Next value exposed so the sequencer can register the result on the final beat.
  always_comb begin
    acc_nxt = acc;
    if (beat) acc_nxt = acc & data;
    acc_zero_nxt = (acc_nxt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      rsp_cnt <= '0;
    end else if (clear) begin
      acc     <= '1;
      rsp_cnt <= '0;
    end else if (beat) begin
      acc     <= acc_nxt;
      rsp_cnt <= rsp_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tcam_search_sequencer.sv
// Runs one fragmented TCAM search over SDRAM segment reads and reports the match.
// Optional early exit on an all-zero accumulator: define TCAM_EARLY_EXIT_EN.
module tcam_search_sequencer
  import tcam_pkg::*;
#(
  parameter int unsigned DATA_BITS = 10,
  parameter int unsigned FRAGMENTS = 5,
  parameter int unsigned FRAG_BITS = 3,
  parameter int unsigned RULES     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_key_valid,
  output logic                 o_key_ready,
  input  logic [DATA_BITS-1:0] i_key,
  output logic                 o_rd_req,
  input  logic                 i_rd_ack,
  output logic [addr_wid(FRAG_BITS, frag_wid(DATA_BITS, FRAGMENTS))-1:0] o_rd_addr,
  input  logic                 i_rd_valid,
  input  logic [RULES-1:0]     i_rd_data,
  output logic                 o_match_valid,
  output logic [RULES-1:0]     o_match_vec,
  output logic                 o_hit,
  output logic                 o_busy
);

  localparam int unsigned FRAG_WID = frag_wid(DATA_BITS, FRAGMENTS);
  localparam int unsigned ADDR_WID = addr_wid(FRAG_BITS, FRAG_WID);
  localparam int unsigned CNT_W    = clog2(FRAGMENTS + 1);

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] key_q;
  logic [DATA_BITS-1:0] key_shift;
  logic [CNT_W-1:0]     iss_cnt;
  logic [CNT_W-1:0]     rsp_cnt;
  logic [RULES-1:0]     acc_nxt;
  logic                 acc_zero_nxt;
  logic                 accept;
  logic                 beat;
  logic                 rd_req_c;
  logic [ADDR_WID-1:0]  rd_addr_c;
  logic                 done_beat_c;
  logic                 stop_c;

  assign accept    = (state == IDLE) && i_key_valid;
  // Responses beyond the issued count are protocol violations and are dropped.
  assign beat      = (state == RUN) && i_rd_valid && (rsp_cnt != iss_cnt);
  assign key_shift = key_q >> (FRAG_WID * 32'(iss_cnt));

  tcam_match_accumulator #(
    .RULES (RULES),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk          (clk),
    .reset        (reset),
    .clear        (accept),
    .beat         (beat),
    .data         (i_rd_data),
    .acc_nxt      (acc_nxt),
    .acc_zero_nxt (acc_zero_nxt),
    .rsp_cnt      (rsp_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rd_req_c    = 1'b0;
    rd_addr_c   = '0;
    stop_c      = 1'b0;
    done_beat_c = 1'b0;
`ifdef TCAM_EARLY_EXIT_EN
    // A zero accumulator cannot recover, so stop issuing and drain what is in flight.
    stop_c      = acc_zero_nxt;
    done_beat_c = beat && ((rsp_cnt == CNT_W'(FRAGMENTS - 1)) ||
                           (acc_zero_nxt && ((rsp_cnt + CNT_W'(1)) == iss_cnt)));
`else
    done_beat_c = beat && (rsp_cnt == CNT_W'(FRAGMENTS - 1));
`endif
    case (state)
      IDLE: if (i_key_valid) state_nxt = RUN;
      RUN: begin
        rd_req_c = (iss_cnt < CNT_W'(FRAGMENTS)) && !stop_c;
        if (done_beat_c) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rd_req_c) rd_addr_c = {FRAG_BITS'(iss_cnt), key_shift[FRAG_WID-1:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q         <= '0;
      iss_cnt       <= '0;
      o_match_valid <= 1'b0;
      o_match_vec   <= '0;
      o_hit         <= 1'b0;
    end else begin
      o_match_valid <= done_beat_c;
      if (accept) begin
        key_q   <= i_key;
        iss_cnt <= '0;
      end else if (rd_req_c && i_rd_ack) begin
        iss_cnt <= iss_cnt + CNT_W'(1);
      end
      if (done_beat_c) begin
        o_match_vec <= acc_nxt;
        o_hit       <= !acc_zero_nxt;
      end
    end
  end

  assign o_key_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign o_rd_req    = rd_req_c;
  assign o_rd_addr   = rd_addr_c;

endmodule

// File: tb/tb_tcam_search_sequencer.sv
// Directed bench for tcam_search_sequencer with a cycle-accurate SDRAM responder.
module tb_tcam_search_sequencer;

  logic       clk;
  logic       reset;
  logic       i_key_valid;
  logic       o_key_ready;
  logic [9:0] i_key;
  logic       o_rd_req;
  logic       i_rd_ack;
  logic [4:0] o_rd_addr;
  logic       i_rd_valid;
  logic [7:0] i_rd_data;
  logic       o_match_valid;
  logic [7:0] o_match_vec;
  logic       o_hit;
  logic       o_busy;

  int errors = 0;
  int checks = 0;

  int         n_iss;
  logic [4:0] issued [0:7];
  int         lat;
  logic [7:0] res_vec;
  logic       res_hit;
  int         kr_bad;
  int         stall_seen;
  int         stall_bad;
  logic [4:0] stall_addr;

  localparam logic [9:0] KEY_A = 10'b11_10_01_00_11;

  tcam_search_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .i_key_valid   (i_key_valid),
    .o_key_ready   (o_key_ready),
    .i_key         (i_key),
    .o_rd_req      (o_rd_req),
    .i_rd_ack      (i_rd_ack),
    .o_rd_addr     (o_rd_addr),
    .i_rd_valid    (i_rd_valid),
    .i_rd_data     (i_rd_data),
    .o_match_valid (o_match_valid),
    .o_match_vec   (o_match_vec),
    .o_hit         (o_hit),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offers a key, acks every request (except a stall window) and returns data one cycle after ack.
  task automatic run_search(input logic [9:0] key, input logic [4:0][7:0] data,
                            input int stall_frag, input int stall_n, input bit hold_key);
    logic       pv;
    logic [7:0] pd;
    int         k;
    int         left;
    bit         done;
    n_iss = 0; lat = -1; kr_bad = 0; stall_seen = 0; stall_bad = 0;
    stall_addr = '0; res_vec = '0; res_hit = 1'b0;
    pv = 1'b0; pd = '0; left = stall_n; done = 1'b0;
    @(negedge clk);
    i_key = key;
    i_key_valid = 1'b1;
    @(posedge clk);
    k = 1;
    @(negedge clk);
    if (!hold_key) i_key_valid = 1'b0;
    while (!done && k < 60) begin
      i_rd_valid = pv;
      i_rd_data  = pd;
      #1;
      if (o_key_ready !== 1'b0) kr_bad++;
      if (o_match_valid === 1'b1) begin
        done = 1'b1; lat = k; res_vec = o_match_vec; res_hit = o_hit;
      end
      pv = 1'b0;
      if (o_rd_req === 1'b1) begin
        if (n_iss == stall_frag && left > 0) begin
          left--; stall_seen++; stall_addr = o_rd_addr; i_rd_ack = 1'b0;
        end else begin
          i_rd_ack = 1'b1;
          if (n_iss < 8) issued[n_iss] = o_rd_addr;
          pd = (n_iss < 5) ? data[n_iss] : 8'hFF;
          pv = 1'b1;
          n_iss++;
        end
      end else begin
        i_rd_ack = 1'b0;
        if (n_iss == stall_frag && left > 0 && left < stall_n) stall_bad++;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    i_rd_valid = 1'b0;
    i_rd_ack   = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (o_key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b want 1", o_key_ready); end
    checks++; if (o_rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", o_rd_req); end
    checks++; if (o_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd_addr: got %h want 00", o_rd_addr); end
    checks++; if (o_match_valid !== 1'b0) begin errors++; $display("FAIL reset_match_valid: got %b want 0", o_match_valid); end
    checks++; if (o_match_vec !== 8'h00) begin errors++; $display("FAIL reset_match_vec: got %h want 00", o_match_vec); end
    checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", o_hit); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [4:0][7:0] d;
    logic [4:0]      exp_addr [0:4];
    exp_addr = '{5'd3, 5'd4, 5'd9, 5'd14, 5'd19};
    d = {8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF};
    run_search(KEY_A, d, -1, 0, 1'b0);
    checks++; if (n_iss !== 5) begin errors++; $display("FAIL basic_reads: got %0d want 5", n_iss); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (issued[i] !== exp_addr[i]) begin
        errors++; $display("FAIL basic_addr%0d: got %0d want %0d", i, issued[i], exp_addr[i]);
      end
    end
    checks++; if (res_vec !== 8'h0F) begin errors++; $display("FAIL basic_vec: got %h want 0f", res_vec); end
    checks++; if (res_hit !== 1'b1) begin errors++; $display("FAIL basic_hit: got %b want 1", res_hit); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL basic_latency: got %0d want 7", lat); end
    checks++; if (kr_bad !== 0) begin errors++; $display("FAIL basic_ready_in_run: got %0d want 0", kr_bad); end
    #1;
    checks++; if (o_match_valid !== 1'b0) begin errors++; $display("FAIL basic_strobe_len: got %b want 0", o_match_valid); end
    checks++; if (o_match_vec !== 8'h0F) begin errors++; $display("FAIL basic_vec_hold: got %h want 0f", o_match_vec); end
  endtask

  task automatic test_early_zero();
    logic [4:0][7:0] d;
    int exp_n;
    int exp_lat;
`ifdef TCAM_EARLY_EXIT_EN
    exp_n = 2; exp_lat = 4;
`else
    exp_n = 5; exp_lat = 7;
`endif
    d = {8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'hF0};
    run_search(KEY_A, d, -1, 0, 1'b0);
    checks++; if (n_iss !== exp_n) begin errors++; $display("FAIL zero_reads: got %0d want %0d", n_iss, exp_n); end
    checks++; if (res_vec !== 8'h00) begin errors++; $display("FAIL zero_vec: got %h want 00", res_vec); end
    checks++; if (res_hit !== 1'b0) begin errors++; $display("FAIL zero_hit: got %b want 0", res_hit); end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, exp_lat); end
  endtask

  task automatic test_key_hold();
    logic [4:0][7:0] d;
    d = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_search(KEY_A, d, -1, 0, 1'b1);
    checks++; if (kr_bad !== 0) begin errors++; $display("FAIL hold_ready_in_run: got %0d want 0", kr_bad); end
    checks++; if (n_iss !== 5) begin errors++; $display("FAIL hold_reads: got %0d want 5", n_iss); end
    checks++; if (res_vec !== 8'hFF) begin errors++; $display("FAIL hold_vec: got %h want ff", res_vec); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL hold_latency: got %0d want 7", lat); end
    #1;
    checks++; if (o_key_ready !== 1'b1) begin errors++; $display("FAIL hold_idle_ready: got %b want 1", o_key_ready); end
    @(posedge clk);
    @(negedge clk);
    i_key_valid = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL hold_second_accept: got %b want 1", o_busy); end
    checks++; if (o_rd_addr !== 5'd3) begin errors++; $display("FAIL hold_second_addr: got %0d want 3", o_rd_addr); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_stall();
    logic [4:0][7:0] d;
    d = {8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF};
    run_search(KEY_A, d, 1, 3, 1'b0);
    checks++; if (stall_seen !== 3) begin errors++; $display("FAIL stall_cycles: got %0d want 3", stall_seen); end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_req_drop: got %0d want 0", stall_bad); end
    checks++; if (stall_addr !== 5'd4) begin errors++; $display("FAIL stall_addr: got %0d want 4", stall_addr); end
    checks++; if (issued[1] !== 5'd4) begin errors++; $display("FAIL stall_issued1: got %0d want 4", issued[1]); end
    checks++; if (n_iss !== 5) begin errors++; $display("FAIL stall_reads: got %0d want 5", n_iss); end
    checks++; if (res_vec !== 8'h0F) begin errors++; $display("FAIL stall_vec: got %h want 0f", res_vec); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL stall_latency: got %0d want 10", lat); end
  endtask

  task automatic test_reset_mid();
    logic [4:0][7:0] d;
    int mv;
    @(negedge clk);
    i_key = KEY_A;
    i_key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_key_valid = 1'b0;
    i_rd_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_rd_valid = 1'b1;
    i_rd_data = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    i_rd_ack = 1'b0;
    i_rd_valid = 1'b1;
    i_rd_data = 8'h00;
    #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", o_busy); end
    reset = 1'b1;
    #1;
    checks++; if (o_key_ready !== 1'b1) begin errors++; $display("FAIL mid_key_ready: got %b want 1", o_key_ready); end
    checks++; if (o_rd_req !== 1'b0) begin errors++; $display("FAIL mid_rd_req: got %b want 0", o_rd_req); end
    checks++; if (o_rd_addr !== 5'd0) begin errors++; $display("FAIL mid_rd_addr: got %0d want 0", o_rd_addr); end
    checks++; if (o_match_vec !== 8'h00) begin errors++; $display("FAIL mid_match_vec: got %h want 00", o_match_vec); end
    checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL mid_hit: got %b want 0", o_hit); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", o_busy); end
    i_rd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_match_valid !== 1'b0) mv++;
    end
    checks++; if (mv !== 0) begin errors++; $display("FAIL mid_no_strobe: got %0d want 0", mv); end
    d = {8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF};
    run_search(KEY_A, d, -1, 0, 1'b0);
    checks++; if (res_vec !== 8'h0F) begin errors++; $display("FAIL mid_next_vec: got %h want 0f", res_vec); end
    checks++; if (issued[2] !== 5'd9) begin errors++; $display("FAIL mid_next_addr2: got %0d want 9", issued[2]); end
  endtask

  task automatic test_spurious();
    logic [4:0][7:0] d;
    @(negedge clk);
    i_rd_valid = 1'b1;
    i_rd_data = 8'h00;
    @(negedge clk);
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL spur_busy: got %b want 0", o_busy); end
    @(negedge clk);
    i_rd_valid = 1'b0;
    d = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_search(10'b01_11_00_10_01, d, -1, 0, 1'b0);
    checks++; if (res_vec !== 8'hFF) begin errors++; $display("FAIL spur_vec: got %h want ff", res_vec); end
    checks++; if (res_hit !== 1'b1) begin errors++; $display("FAIL spur_hit: got %b want 1", res_hit); end
    checks++; if (issued[3] !== 5'd15) begin errors++; $display("FAIL spur_addr3: got %0d want 15", issued[3]); end
  endtask

  initial begin
    reset = 1'b1;
    i_key_valid = 1'b0;
    i_key = '0;
    i_rd_ack = 1'b0;
    i_rd_valid = 1'b0;
    i_rd_data = '0;
    test_reset();
    test_basic();
    test_early_zero();
    test_key_hold();
    test_stall();
    test_reset_mid();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
